// File: rtl/poly_pointwise_mul.sv
// Pointwise Montgomery multiplier for NewHope polynomials: C[k] = montgomery_reduce(A[k]*B[k]).
// Streams both operand RAMs in lockstep through a 3-stage multiply/reduce pipeline.
module poly_pointwise_mul #(
  parameter int N      = 512,
  parameter int ADDR_W = 9,
  parameter int Q      = 12289,
  parameter int QINV   = 12287,
  parameter int RLOG   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] poly_a_addr,
  input  logic [15:0]       poly_a_do,
  output logic [ADDR_W-1:0] poly_b_addr,
  input  logic [15:0]       poly_b_do,
  output logic              poly_c_wea,
  output logic [ADDR_W-1:0] poly_c_addr,
  output logic [15:0]       poly_c_dia
);

  localparam int PW = 32;
  localparam int TW = PW + 2;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);
  localparam logic [RLOG-1:0]   QINV_C = RLOG'(QINV);
  localparam logic [TW-1:0]     Q_C    = TW'(Q);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic              done_next;

  // valid/address of the coefficient currently coming out of the RAMs
  logic              rd_v;
  logic [ADDR_W-1:0] rd_k;

  logic              s1_v;
  logic [ADDR_W-1:0] s1_k;
  logic [PW-1:0]     s1_p;

  logic              s2_v;
  logic [ADDR_W-1:0] s2_k;
  logic [PW-1:0]     s2_p;
  logic [RLOG-1:0]   s2_u;

  logic [RLOG-1:0]   u_calc;
  logic [TW-1:0]     t_calc;
  logic [15:0]       t_hi;

  assign busy        = (state != IDLE);
  assign poly_a_addr = addr;
  assign poly_b_addr = addr;

  always_comb begin
    state_next = state;
    addr_next  = '0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (addr == LAST) state_next = DRAIN;
        else              addr_next  = addr + 1'b1;
      end
      DRAIN: begin
        // the pass ends once the last coefficient's write has been presented
        if (poly_c_wea && (poly_c_addr == LAST)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      done  <= done_next;
    end
  end

  // low RLOG bits only: the truncated product is (p*QINV) mod 2^RLOG
  assign u_calc = s1_p[RLOG-1:0] * QINV_C;
  assign t_calc = TW'(s2_p) + (TW'(s2_u) * Q_C);
  assign t_hi   = 16'(t_calc >> RLOG);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_v        <= 1'b0;
      rd_k        <= '0;
      s1_v        <= 1'b0;
      s1_k        <= '0;
      s1_p        <= '0;
      s2_v        <= 1'b0;
      s2_k        <= '0;
      s2_p        <= '0;
      s2_u        <= '0;
      poly_c_wea  <= 1'b0;
      poly_c_addr <= '0;
      poly_c_dia  <= '0;
    end else begin
      rd_v <= (state == RUN);
      rd_k <= addr;

      s1_v <= rd_v;
      s1_k <= rd_k;
      s1_p <= PW'(poly_a_do) * PW'(poly_b_do);

      s2_v <= s1_v;
      s2_k <= s1_k;
      s2_p <= s1_p;
      s2_u <= u_calc;

      // address and data are forced to zero on idle cycles
      poly_c_wea  <= s2_v;
      poly_c_addr <= s2_v ? s2_k : '0;
      poly_c_dia  <= s2_v ? t_hi : '0;
    end
  end

endmodule

// File: tb/tb_poly_pointwise_mul.sv
// Self-checking bench for poly_pointwise_mul: RAM models, a timing/arithmetic reference model
// evaluated every cycle, and end-of-pass content checks of the captured C RAM.
module tb_poly_pointwise_mul;

  localparam int N = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [8:0]  a_addr, b_addr, c_addr;
  logic [15:0] a_do, b_do, c_dia;
  logic        c_wea;

  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  logic [15:0] mem_c [N];
  logic [15:0] snap_c [N];

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = -1;
  int m_passes = 0;
  int dut_dones = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  poly_pointwise_mul dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .poly_a_addr(a_addr), .poly_a_do(a_do),
    .poly_b_addr(b_addr), .poly_b_do(b_do),
    .poly_c_wea(c_wea), .poly_c_addr(c_addr), .poly_c_dia(c_dia)
  );

  // registered-read RAMs for A and B
  always @(posedge clk) begin
    a_do <= mem_a[a_addr];
    b_do <= mem_b[b_addr];
  end

  always @(negedge clk) begin
    if (c_wea) mem_c[c_addr] = c_dia;
  end

  function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b);
    longint unsigned p, u, t;
    p = a * b;
    u = (p * 64'd12287) % 64'd262144;
    t = p + u * 64'd12289;
    return t / 64'd262144;
  endfunction

  task automatic check_output(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // pass timeline model: m_cnt = index j of the most recent edge E_j of the current pass, -1 when idle
  always @(posedge clk) begin
    if (!rst) m_cnt = -1;
    else if (m_cnt >= 0 && m_cnt < 516) begin
      m_cnt++;
      if (m_cnt == 516) m_passes++;
    end else if (start) m_cnt = 0;
    else m_cnt = -1;
  end

  always @(negedge clk) begin
    int k;
    bit wr;
    if (chk_en) begin
      wr = (m_cnt >= 4 && m_cnt <= 515);
      k  = m_cnt - 4;
      check_output("busy", busy, (m_cnt >= 0 && m_cnt <= 515));
      check_output("done", done, (m_cnt == 516));
      check_output("a_addr", a_addr, (m_cnt >= 0 && m_cnt < N) ? m_cnt : 0);
      check_output("b_addr", b_addr, (m_cnt >= 0 && m_cnt < N) ? m_cnt : 0);
      check_output("c_wea", c_wea, wr);
      check_output("c_addr", c_addr, wr ? k : 0);
      check_output("c_dia", c_dia, wr ? mont(mem_a[k], mem_b[k]) : 0);
      if (done) dut_dones++;
    end
  end

  task automatic apply_stimulus(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin mem_a[k] = 16'd1;     mem_b[k] = 16'd1; end
        1: begin mem_a[k] = 16'd12289; mem_b[k] = 16'(k + 1); end
        2: begin mem_a[k] = 16'd0;     mem_b[k] = 16'd61444; end
        3: begin mem_a[k] = 16'd61444; mem_b[k] = 16'd61444; end
        default: begin
          mem_a[k] = 16'($urandom_range(61444, 0));
          mem_b[k] = 16'($urandom_range(61444, 0));
        end
      endcase
      mem_c[k] = 16'hFFFF;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (cyc < 800) begin
      @(negedge clk);
      if (done) break;
      cyc++;
    end
    if (cyc >= 800) check_output("done_timeout", 0, 1);
  endtask

  task automatic check_c_model();
    for (int k = 0; k < N; k++) check_output("c_mem", mem_c[k], mont(mem_a[k], mem_b[k]));
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_output("reset_busy", busy, 0);
    check_output("reset_wea", c_wea, 0);
    rst = 1'b1;

    check_output("model_1x1", mont(1, 1), 576);
    check_output("model_q", mont(12289, 7), 12289);
    check_output("model_zero", mont(0, 61444), 0);

    apply_stimulus(0);
    pulse_start();
    wait_done();
    check_c_model();
    check_output("ones_c0", mem_c[0], 576);
    check_output("ones_c511", mem_c[511], 576);

    apply_stimulus(1);
    pulse_start();
    wait_done();
    check_c_model();
    check_output("q_c0", mem_c[0], 12289);
    check_output("q_c300", mem_c[300], 12289);

    apply_stimulus(2);
    pulse_start();
    wait_done();
    check_c_model();
    check_output("zero_c17", mem_c[17], 0);

    apply_stimulus(3);
    pulse_start();
    wait_done();
    check_c_model();
    check_output("max_lt_2p15", mem_c[5] < 16'd32768, 1);
    check_output("max_congruent", (longint'(mem_c[5]) * 262144 - 64'd61444 * 64'd61444) % 12289, 0);

    apply_stimulus(4);
    pulse_start();
    wait_done();
    check_c_model();

    // reset when 200 addresses (0..199) have been issued, then restart
    apply_stimulus(4);
    pulse_start();
    cyc = 0;
    while (m_cnt != 199 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 1000) check_output("reset_point_timeout", 0, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_output("midreset_busy", busy, 0);
    check_output("midreset_addr", a_addr, 0);
    check_output("midreset_dia", c_dia, 0);
    repeat (10) @(posedge clk);
    for (int k = 0; k < N; k++) mem_c[k] = 16'hFFFF;
    pulse_start();
    wait_done();
    check_c_model();

    // start held for the whole pass gives exactly one pass
    apply_stimulus(4);
    @(posedge clk); #1;
    start = 1'b1;
    cyc = 0;
    while (m_cnt != 515 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 1000) check_output("hold_timeout", 0, 1);
    start = 1'b0;
    wait_done();
    check_c_model();
    repeat (5) @(negedge clk);
    check_output("no_second_pass", busy, 0);

    // back-to-back restart in the done cycle
    apply_stimulus(4);
    pulse_start();
    wait_done();
    for (int k = 0; k < N; k++) snap_c[k] = mem_c[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("b2b_busy", busy, 1);
    check_output("b2b_addr0", a_addr, 0);
    for (int k = 0; k < N; k++) mem_c[k] = 16'hFFFF;
    wait_done();
    for (int k = 0; k < N; k++) check_output("b2b_same", mem_c[k], snap_c[k]);
    check_c_model();

    repeat (3) @(negedge clk);
    check_output("done_count", dut_dones, m_passes);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
